// File: rtl/fir_pkg.sv
// Shared FIR widths and output saturation limits, used by the FIR core and its output stage.
package fir_pkg;

  localparam int X_N_SIZE   = 8;
  localparam int Y_N_SIZE   = 14;
  localparam int OUT_SIZE   = 8;
  localparam int FIFO_DEPTH = 4;

  // Two's-complement limits of a signed field of width w.
  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX = sat_hi(OUT_SIZE);
  localparam int SAT_MIN = sat_lo(OUT_SIZE);

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through output buffer; occupancy is kept in its own counter.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A push into a full buffer is still taken when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: capture, round-by-shift, saturate, then buffer samples for an AXI-Stream-style consumer.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int Y_N_SIZE   = fir_pkg::Y_N_SIZE,
  parameter int OUT_SIZE   = fir_pkg::OUT_SIZE,
  parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [Y_N_SIZE-1:0] y_n,
  input  logic                       y_valid,
  input  logic [2:0]                 shift,
  output logic signed [OUT_SIZE-1:0] m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [2:0]                 level,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  input  logic                       clr_flags
);

  localparam int RW   = Y_N_SIZE + 1;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int HI_I = sat_hi(OUT_SIZE);
  localparam int LO_I = sat_lo(OUT_SIZE);
  localparam logic signed [RW-1:0] HI_R = RW'(HI_I);
  localparam logic signed [RW-1:0] LO_R = RW'(LO_I);

  logic signed [Y_N_SIZE-1:0] y1;
  logic [2:0]                 s1;
  logic                       v1;

  logic signed [RW-1:0]       y_ext;
  logic signed [RW-1:0]       rnd_add;
  logic signed [RW-1:0]       r_next;

  logic signed [RW-1:0]       r2;
  logic                       v2;

  logic [OUT_SIZE-1:0]        d_sat;
  logic                       sat_next;

  logic [OUT_SIZE-1:0]        d3;
  logic                       sat3;
  logic                       v3;

  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [OUT_SIZE-1:0]        fifo_rd;
  logic [LW-1:0]              fifo_level;
  logic                       sat_set;
  logic                       ovf_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y1 <= '0;
      s1 <= '0;
      v1 <= 1'b0;
    end else begin
      y1 <= y_n;
      s1 <= shift;
      v1 <= y_valid;
    end
  end

  // One extra bit of headroom keeps the half-LSB rounding add from overflowing.
  always_comb begin
    y_ext   = {y1[Y_N_SIZE-1], y1};
    rnd_add = '0;
    if (s1 != 3'd0) rnd_add = RW'(1) << (s1 - 3'd1);
    r_next  = (y_ext + rnd_add) >>> s1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r2 <= '0;
      v2 <= 1'b0;
    end else begin
      r2 <= r_next;
      v2 <= v1;
    end
  end

  always_comb begin
    d_sat    = r2[OUT_SIZE-1:0];
    sat_next = 1'b0;
    if (r2 > HI_R) begin
      d_sat    = HI_R[OUT_SIZE-1:0];
      sat_next = 1'b1;
    end else if (r2 < LO_R) begin
      d_sat    = LO_R[OUT_SIZE-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d3   <= '0;
      sat3 <= 1'b0;
      v3   <= 1'b0;
    end else begin
      d3   <= d_sat;
      sat3 <= sat_next;
      v3   <= v2;
    end
  end

  assign pop = m_tvalid && m_tready;

  fir_out_fifo #(
    .WIDTH (OUT_SIZE),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (v3),
    .pop     (pop),
    .wr_data (d3),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_rd;
  assign level    = 3'(fifo_level);

  // A saturated sample marks sat_flag whether or not the buffer had room for it.
  assign sat_set = v3 && sat3;
  assign ovf_set = v3 && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (sat_set)        sat_flag <= 1'b1;
      else if (clr_flags) sat_flag <= 1'b0;
      if (ovf_set)        ovf_flag <= 1'b1;
      else if (clr_flags) ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage: directed and random samples checked against a queue-based arithmetic model.
module tb_fir_out_stage;

  localparam int Y_N_SIZE   = 14;
  localparam int OUT_SIZE   = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int OUT_MAX    = (1 << (OUT_SIZE - 1)) - 1;
  localparam int OUT_MIN    = -(1 << (OUT_SIZE - 1));

  logic                       clk = 1'b0;
  logic                       reset;
  logic signed [Y_N_SIZE-1:0] y_n;
  logic                       y_valid;
  logic [2:0]                 shift;
  logic signed [OUT_SIZE-1:0] m_tdata;
  logic                       m_tvalid;
  logic                       m_tready;
  logic [2:0]                 level;
  logic                       sat_flag;
  logic                       ovf_flag;
  logic                       clr_flags;

  typedef struct {
    int due;
    int val;
    bit sat;
  } inflight_t;

  inflight_t pipeQ[$];
  int        fifoQ[$];
  bit        expSat;
  bit        expOvf;
  int        cyc          = 0;
  int        checksTotal  = 0;
  int        checksPassed = 0;

  fir_out_stage #(
    .Y_N_SIZE   (Y_N_SIZE),
    .OUT_SIZE   (OUT_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .y_n       (y_n),
    .y_valid   (y_valid),
    .shift     (shift),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .level     (level),
    .sat_flag  (sat_flag),
    .ovf_flag  (ovf_flag),
    .clr_flags (clr_flags)
  );

  always #5 clk = ~clk;

  // Round half up after dividing by 2^s, then clamp to the output range.
  function automatic int expectSample(input int y, input int s, output bit sat);
    int r;
    r   = (s == 0) ? y : ((y + (1 << (s - 1))) >>> s);
    sat = 1'b0;
    if (r > OUT_MAX) begin
      r   = OUT_MAX;
      sat = 1'b1;
    end else if (r < OUT_MIN) begin
      r   = OUT_MIN;
      sat = 1'b1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checksTotal++;
    assert (obs === exp) checksPassed++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advances the model by one rising edge using the inputs present at that edge.
  task automatic modelEdge();
    bit        doPop;
    bit        fullBefore;
    bit        wr;
    int        wv;
    bit        ws;
    bit        satSet;
    bit        ovfSet;
    inflight_t e;
    doPop      = (fifoQ.size() > 0) && m_tready;
    fullBefore = (fifoQ.size() == FIFO_DEPTH);
    wr = 1'b0;
    wv = 0;
    ws = 1'b0;
    if (pipeQ.size() > 0 && pipeQ[0].due == cyc) begin
      wr = 1'b1;
      wv = pipeQ[0].val;
      ws = pipeQ[0].sat;
      void'(pipeQ.pop_front());
    end
    satSet = wr && ws;
    ovfSet = 1'b0;
    if (doPop) void'(fifoQ.pop_front());
    if (wr) begin
      if (!fullBefore || doPop) fifoQ.push_back(wv);
      else ovfSet = 1'b1;
    end
    if (satSet) expSat = 1'b1;
    else if (clr_flags) expSat = 1'b0;
    if (ovfSet) expOvf = 1'b1;
    else if (clr_flags) expOvf = 1'b0;
    if (y_valid) begin
      e.due = cyc + 3;
      e.val = expectSample(int'(y_n), int'(shift), e.sat);
      pipeQ.push_back(e);
    end
    cyc++;
  endtask

  task automatic checkOutput();
    check("m_tvalid", m_tvalid, fifoQ.size() > 0);
    check("level", level, fifoQ.size());
    check("sat_flag", sat_flag, expSat);
    check("ovf_flag", ovf_flag, expOvf);
    if (fifoQ.size() > 0) check("m_tdata", m_tdata, fifoQ[0]);
  endtask

  task automatic applyStimulus(input bit yv, input int y, input int s, input bit rdy, input bit clr);
    y_valid   = yv;
    y_n       = 14'(y);
    shift     = 3'(s);
    m_tready  = rdy;
    clr_flags = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    pipeQ.delete();
    fifoQ.delete();
    expSat = 1'b0;
    expOvf = 1'b0;
    checkOutput();
    check("m_tdata_rst", m_tdata, 0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    y_n       = '0;
    y_valid   = 1'b0;
    shift     = '0;
    m_tready  = 1'b0;
    clr_flags = 1'b0;
    expSat    = 1'b0;
    expOvf    = 1'b0;
    #2;
    checkOutput();
    check("m_tdata_rst", m_tdata, 0);
    #1;
    reset = 1'b1;

    // Rounding cases that stay inside the output range.
    applyStimulus(1'b1, 5, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, -6, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, -7, 0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    // Saturation at both limits, then a flag clear.
    applyStimulus(1'b1, 300, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, -300, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, -8192, 7, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    // Single pulse held in the buffer, then popped.
    applyStimulus(1'b1, 42, 3, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    // Overflow with a stalled consumer, then drain in order.
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, i, 0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    check("level_full", level, FIFO_DEPTH);
    repeat (6) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

    // Continuous input that reaches a full buffer just as the consumer starts draining.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 10 + i, 0, (i >= 7), 1'b0);
    repeat (8) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    // Random traffic across the full input range.
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3) != 0, int'($signed(14'($urandom))),
                    int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);
    repeat (8) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    // Reset with three buffered samples and two still in the pipeline.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 20 + i, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    check("level_pre_rst", level, 3);
    doReset();
    repeat (10) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
